mpu6050_i2c_responder: RTL

- I2C target that emulates the MPU6050 register interface seen by the gyro driver's I2C master.
- Used as an on-chip loopback/simulation stand-in for the physical gyro, and to exercise the master without the sensor.
- Presents a small register file. GYRO_ZOUT is sourced from a 16-bit input, so the robot yaw path can be driven with known rates.
- Sits beside the gyro driver on the SCL/SDA nets (open-drain; the block only pulls SDA low).

---
 rtl/mpu6050_i2c_responder.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mpu6050_i2c_responder.sv
// I2C target emulating the MPU6050 register interface for the gyro driver.
// Open-drain: only ever pulls SDA low; GYRO_ZOUT comes from gyro_z.
module mpu6050_i2c_responder #(
  parameter logic [6:0] DEV_ADDR       = 7'h68,
  parameter logic [7:0] WHO_AM_I_VAL   = 8'h68,
  parameter logic [7:0] PWR_MGMT_1_RST = 8'h40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] gyro_z,
  output logic [7:0]  pwr_mgmt_1,
  output logic [7:0]  smplrt_div,
  output logic [7:0]  int_enable,
  output logic        busy,
  output logic        wr_strobe,
  output logic [7:0]  wr_addr
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_t;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_h_q, sda_h_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_h_q    <= 1'b1;
      sda_h_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_h_q    <= scl_sync_q[1];
      sda_h_q    <= sda_sync_q[1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_s    = scl_sync_q[1];
  assign sda_s    = sda_sync_q[1];
  assign scl_rise = scl_s & ~scl_h_q;
  assign scl_fall = ~scl_s & scl_h_q;
  assign start_ev = scl_s & scl_h_q & sda_h_q & ~sda_s;
  assign stop_ev  = scl_s & scl_h_q & ~sda_h_q & sda_s;

  state_t      state_q, state_d;
  logic [7:0]  sh_q, sh_d, ptr_q, ptr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d, rw_q, rw_d;
  logic        oe_q, oe_d, busy_q, busy_d;
  logic        wrs_q, wrs_d;
  logic [7:0]  wra_q, wra_d;
  logic [7:0]  pwr_q, pwr_d, smp_q, smp_d, ien_q, ien_d;
  logic [15:0] snap_q, snap_d;

  logic [7:0] sh_in, rd_val;
  logic       first_rd, snap_ld;
  assign sh_in    = {sh_q[6:0], sda_s};
  assign first_rd = (state_q == ADDR_ACK);

  // A burst read of 0x47 then 0x48 must see one coherent sample.
  always_comb begin
    rd_val  = 8'h00;
    snap_ld = 1'b0;
    case (ptr_q)
      8'h75: rd_val = WHO_AM_I_VAL;
      8'h47: begin
        rd_val  = gyro_z[15:8];
        snap_ld = 1'b1;
      end
      8'h48: begin
        rd_val  = first_rd ? gyro_z[7:0] : snap_q[7:0];
        snap_ld = first_rd;
      end
      8'h6B: rd_val = pwr_q;
      8'h19: rd_val = smp_q;
      8'h38: rd_val = ien_q;
      default: rd_val = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    wrs_d   = 1'b0;
    wra_d   = wra_q;
    pwr_d   = pwr_q;
    smp_d   = smp_q;
    ien_d   = ien_q;
    snap_d  = snap_q;
    if (!enable) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (stop_ev) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_ev) begin
      state_d = ADDR;
      oe_d    = 1'b0;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          sh_d  = sh_in;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            ack_d = 1'b0;
            if (sh_in[7:1] == DEV_ADDR) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = sh_in[0];
            end else begin
              state_d = IGNORE;
            end
          end
        end
        PTR, WDATA: if (scl_rise) begin
          sh_d  = sh_in;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            ack_d = 1'b0;
            if (state_q == PTR) begin
              ptr_d   = sh_in;
              state_d = PTR_ACK;
            end else begin
              case (ptr_q)
                8'h6B:   pwr_d = sh_in;
                8'h19:   smp_d = sh_in;
                8'h38:   ien_d = sh_in;
                default: ;
              endcase
              wrs_d   = 1'b1;
              wra_d   = ptr_q;
              ptr_d   = ptr_q + 8'd1;
              state_d = WDATA_ACK;
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (!ack_q) begin
            oe_d  = 1'b1;
            ack_d = 1'b1;
          end else begin
            ack_d = 1'b0;
            cnt_d = 3'd0;
            if (state_q == ADDR_ACK && rw_q) begin
              state_d = RDATA;
              sh_d    = rd_val;
              oe_d    = ~rd_val[7];
              if (snap_ld) snap_d = gyro_z;
            end else begin
              state_d = (state_q == ADDR_ACK) ? PTR : WDATA;
              oe_d    = 1'b0;
            end
          end
        end
        RDATA: if (scl_fall) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            oe_d    = 1'b0;
            ptr_d   = ptr_q + 8'd1;
            ack_d   = 1'b0;
            state_d = RACK;
          end else begin
            sh_d = {sh_q[6:0], 1'b0};
            oe_d = ~sh_q[6];
          end
        end
        RACK: begin
          if (scl_rise) begin
            if (sda_s) state_d = IGNORE;
            else       ack_d   = 1'b1;
          end else if (scl_fall && ack_q) begin
            ack_d   = 1'b0;
            cnt_d   = 3'd0;
            state_d = RDATA;
            sh_d    = rd_val;
            oe_d    = ~rd_val[7];
            if (snap_ld) snap_d = gyro_z;
          end
        end
        IGNORE:  oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= 8'h00;
      ptr_q   <= 8'h00;
      cnt_q   <= 3'd0;
      ack_q   <= 1'b0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      wrs_q   <= 1'b0;
      wra_q   <= 8'h00;
      pwr_q   <= PWR_MGMT_1_RST;
      smp_q   <= 8'h00;
      ien_q   <= 8'h00;
      snap_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      wrs_q   <= wrs_d;
      wra_q   <= wra_d;
      pwr_q   <= pwr_d;
      smp_q   <= smp_d;
      ien_q   <= ien_d;
      snap_q  <= snap_d;
    end
  end

  assign sda_oe     = oe_q;
  assign busy       = busy_q;
  assign wr_strobe  = wrs_q;
  assign wr_addr    = wra_q;
  assign pwr_mgmt_1 = pwr_q;
  assign smplrt_div = smp_q;
  assign int_enable = ien_q;

endmodule
